spi_rx: RTL and testbench

- SPI 8-bit input receiver; the responder end of the team's SPI output driver.
- Samples an external SPI bus (cs_, sck, sdi, dc_), assembles MSB-first bytes tagged with the D/C bit, and buffers them in a small FIFO.
- The CPU reads the FIFO through a memory-mapped word at 32'hff10; the top level decodes that address as cs6.
- Used for loopback self-test of the display driver and for external SPI masters.

---
 rtl/spi_rx_pkg.sv | 41 ++++
 rtl/spi_rx_fifo.sv | 76 +++++++
 rtl/spi_rx.sv | 181 ++++++++++++++++++
 tb/tb_spi_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI input receiver: FSM state codes, rdata bit
// positions, the CPU-visible address and a helper that packs the read word.
package spi_rx_pkg;

    typedef enum logic [0:0] {
        SPIRX_IDLE  = 1'b0,
        SPIRX_SHIFT = 1'b1
    } spirx_state_e;

    // Bit positions inside the 32-bit read word
    localparam int RX_BYTE_MSB = 7;
    localparam int RX_BYTE_LSB = 0;
    localparam int RX_DC       = 8;
    localparam int RX_VALID    = 9;
    localparam int RX_OVF      = 10;
    localparam int RX_FERR     = 11;

    // FIFO entry: {dc, byte}
    localparam int RX_ENTRY_W  = 9;

    // Memory-mapped location of the receive word (decoded as cs6 at the top)
    localparam logic [31:0] RX_ADDR = 32'hff10;

    // Build {20'h0, ferr, ovf, valid, dc, byte} from the flags and FIFO head
    function automatic logic [31:0] pack_rdata(
        input logic                  ferr,
        input logic                  ovf,
        input logic                  valid,
        input logic [RX_ENTRY_W-1:0] entry
    );
        logic [31:0] word;
        word                          = 32'h0000_0000;
        word[RX_FERR]                 = ferr;
        word[RX_OVF]                  = ovf;
        word[RX_VALID]                = valid;
        word[RX_DC]                   = entry[8];
        word[RX_BYTE_MSB:RX_BYTE_LSB] = entry[7:0];
        return word;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO holding {dc, byte} entries. A push while full is
// accepted only if a pop happens in the same cycle; the head reads as zero
// when the FIFO is empty.
module spi_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [RX_ENTRY_W-1:0] din,
    output logic [RX_ENTRY_W-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q,  count_d;
    logic [RX_ENTRY_W-1:0] mem_q [DEPTH];
    logic                  wr_en_s;
    logic                  rd_en_s;

    assign empty = (count_q == {(AW+1){1'b0}});
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign dout  = empty ? {RX_ENTRY_W{1'b0}} : mem_q[rd_ptr_q];

    // Qualify strobes and compute next pointers and occupancy
    always_comb begin
        rd_en_s  = pop && !empty;
        wr_en_s  = push && (!full || rd_en_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents beyond the occupancy are never observed
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spi_rx.sv
// SPI 8-bit input receiver. Synchronises the SPI bus into clk, assembles
// MSB-first bytes tagged with D/C, buffers them in a FIFO and exposes the
// head plus sticky overflow/framing flags as one CPU-readable word.
module spi_rx
    import spi_rx_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        sck,
    input  logic        sdi,
    input  logic        dc_,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q,  dc_sync_d;
    logic                   cs_hist_q,  sck_hist_q;

    logic cs_s, sck_s, sdi_s, dc_s;
    logic cs_fall_s, cs_rise_s, sck_rise_s;

    spirx_state_e          state_q,  state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [7:0]            shreg_q,  shreg_d;
    logic                  ferr_q,   ferr_d;
    logic                  ovf_q,    ovf_d;
    logic                  push_s;
    logic                  ferr_set_s;
    logic                  ovf_set_s;
    logic                  pop_s;
    logic [RX_ENTRY_W-1:0] push_data_s;
    logic [RX_ENTRY_W-1:0] head_s;
    logic                  fifo_full_s, fifo_empty_s;

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
    assign dc_s  = dc_sync_q[SYNC_STAGES-1];

    assign cs_fall_s  = !cs_s && cs_hist_q;
    assign cs_rise_s  = cs_s && !cs_hist_q;
    assign sck_rise_s = sck_s && !sck_hist_q;

    // Shift each asynchronous input one stage deeper into the clk domain
    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0],  cs_};
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        dc_sync_d  = {dc_sync_q[SYNC_STAGES-2:0],  dc_};
    end

    // Synchroniser and edge-history flops; idle bus is cs_=1, sck=1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q  <= {SYNC_STAGES{1'b1}};
            sck_sync_q <= {SYNC_STAGES{1'b1}};
            sdi_sync_q <= {SYNC_STAGES{1'b0}};
            dc_sync_q  <= {SYNC_STAGES{1'b0}};
            cs_hist_q  <= 1'b1;
            sck_hist_q <= 1'b1;
        end else begin
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            dc_sync_q  <= dc_sync_d;
            cs_hist_q  <= cs_s;
            sck_hist_q <= sck_s;
        end
    end

    // Frame FSM: shift on sck rise, push every 8th bit, flag partial bytes
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        push_s      = 1'b0;
        ferr_set_s  = 1'b0;
        case (state_q)
            SPIRX_IDLE: begin
                if (cs_fall_s) begin
                    state_d  = SPIRX_SHIFT;
                    bitcnt_d = 3'd0;
                end else begin
                    state_d  = SPIRX_IDLE;
                end
            end
            SPIRX_SHIFT: begin
                if (sck_rise_s) begin
                    shreg_d = {shreg_q[6:0], sdi_s};
                    if (bitcnt_q == 3'd7) begin
                        push_s   = 1'b1;
                        bitcnt_d = 3'd0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    shreg_d = shreg_q;
                end
                // A byte completed in this same cycle is pushed, not flagged
                if (cs_rise_s) begin
                    state_d = SPIRX_IDLE;
                    if (bitcnt_d != 3'd0) begin
                        ferr_set_s = 1'b1;
                    end else begin
                        ferr_set_s = 1'b0;
                    end
                    bitcnt_d = 3'd0;
                end else begin
                    state_d = SPIRX_SHIFT;
                end
            end
            default: begin
                state_d  = SPIRX_IDLE;
                bitcnt_d = 3'd0;
            end
        endcase
        push_data_s = {dc_s, shreg_d};
    end

    // Sticky flags: a new event wins over a read-clear in the same cycle
    always_comb begin
        pop_s     = rd && !fifo_empty_s;
        ovf_set_s = push_s && fifo_full_s && !pop_s;
        if (ferr_set_s) begin
            ferr_d = 1'b1;
        end else if (rd) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (rd) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FSM, shifter and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SPIRX_IDLE;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'h00;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
        end
    end

    spi_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (rd),
        .din   (push_data_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign rdata = pack_rdata(ferr_q, ovf_q, !fifo_empty_s, head_s);
    assign irq   = !fifo_empty_s;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx. Stimulus pushes the expected read word
// into a queue before each rd strobe; a separate monitor compares rdata
// against the queue head whenever rd is presented to the DUT.
module tb_spi_rx;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_ = 1'b1;
    logic        sck = 1'b1;
    logic        sdi = 1'b0;
    logic        dc_ = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    spi_rx #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cs_   (cs_),
        .sck   (sck),
        .sdi   (sdi),
        .dc_   (dc_),
        .rd    (rd),
        .rdata (rdata),
        .irq   (irq)
    );

    always #8 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rd strobe is compared against the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rd) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_rd: got %h expected no read", rdata);
                end else begin
                    check("rd_word", rdata, exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog bound on the whole run
    initial begin
        #(16 * 100000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_ = 1'b0;
        wait_neg(HALF);
    endtask

    task automatic cs_high();
        cs_ = 1'b1;
        wait_neg(HALF);
    endtask

    // Send the top n bits of b MSB-first. On the 8th bit, mode 1 checks
    // irq latency and mode 2 issues a rd that coincides with the push.
    task automatic send_bits(input logic [7:0] b, input int n, input logic d,
                             input int mode, input logic [31:0] coll_exp);
        for (int i = 0; i < n; i++) begin
            sck = 1'b0;
            sdi = b[7-i];
            dc_ = d;
            wait_neg(HALF);
            sck = 1'b1;
            if (i == 7 && mode == 1) begin
                for (int k = 1; k <= SYNC + 1; k++) begin
                    @(posedge clk);
                    #1;
                    if (k == SYNC) check("irq_before_latency", {31'b0, irq}, 32'h0);
                    if (k == SYNC + 1) check("irq_at_latency", {31'b0, irq}, 32'h1);
                end
                wait_neg(HALF - SYNC - 1);
            end else if (i == 7 && mode == 2) begin
                for (int k = 1; k <= SYNC; k++) @(posedge clk);
                #1;
                exp_q.push_back(coll_exp);
                rd = 1'b1;
                @(posedge clk);
                #1;
                rd = 1'b0;
                wait_neg(HALF - SYNC - 1);
            end else begin
                wait_neg(HALF);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        send_bits(b, 8, d, 0, 32'h0);
    endtask

    task automatic do_rd(input logic [31:0] e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    initial begin
        // Reset state
        wait_neg(3);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        wait_neg(5);

        // Reset mid-frame discards buffered and partial bytes
        cs_low();
        send_byte(8'h55, 1'b1);
        check("buffered_before_reset", rdata, 32'h0000_0355);
        send_bits(8'hF0, 4, 1'b1, 0, 32'h0);
        reset = 1'b1;
        cs_   = 1'b1;
        sck   = 1'b1;
        #1;
        check("reset_midframe_rdata", rdata, 32'h0);
        check("reset_midframe_irq", {31'b0, irq}, 32'h0);
        wait_neg(2);
        reset = 1'b0;
        wait_neg(5);
        cs_low();
        send_byte(8'h3C, 1'b1);
        cs_high();
        do_rd(32'h0000_033C);
        do_rd(32'h0);

        // Single byte with latency check
        cs_low();
        send_bits(8'hA5, 8, 1'b1, 1, 32'h0);
        cs_high();
        check("single_rdata", rdata, 32'h0000_03A5);
        do_rd(32'h0000_03A5);
        #1;
        check("single_after_rd", rdata, 32'h0);
        check("single_irq_after_rd", {31'b0, irq}, 32'h0);

        // Multi-byte frame
        cs_low();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        cs_high();
        do_rd(32'h0000_0212);
        do_rd(32'h0000_0334);
        do_rd(32'h0);

        // Overflow: fifth byte dropped
        cs_low();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        cs_high();
        do_rd(32'h0000_0601);
        do_rd(32'h0000_0202);
        do_rd(32'h0000_0203);
        do_rd(32'h0000_0204);
        do_rd(32'h0);

        // Framing error after 5 bits
        cs_low();
        send_bits(8'hB8, 5, 1'b1, 0, 32'h0);
        cs_high();
        check("ferr_irq", {31'b0, irq}, 32'h0);
        do_rd(32'h0000_0800);
        do_rd(32'h0);

        // Full FIFO: pop coincides with push of the fifth byte
        cs_low();
        for (int i = 1; i <= 4; i++) send_byte(8'(8'h10 + i), 1'b1);
        send_bits(8'h15, 8, 1'b1, 2, 32'h0000_0311);
        cs_high();
        do_rd(32'h0000_0312);
        do_rd(32'h0000_0313);
        do_rd(32'h0000_0314);
        do_rd(32'h0000_0315);
        do_rd(32'h0);

        // Loopback word 10'h1C7 as the display driver would shift it
        cs_low();
        send_byte(8'hC7, 1'b1);
        cs_high();
        do_rd(32'h0000_03C7);
        do_rd(32'h0);

        wait_neg(2);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
